// File: rtl/jt03_i2s_tx_if.sv
// Sample-side and serial-side signals of the jt03 I2S transmitter.
// master = sample producer / DAC observer, slave = transmitter.
interface jt03_i2s_tx_if;
    logic signed [15:0] left;
    logic signed [15:0] right;
    logic               sample;
    logic               sclk;
    logic               lrck;
    logic               sdata;
    logic               underrun;
    logic               overrun;

    modport master (
        output left, right, sample,
        input  sclk, lrck, sdata, underrun, overrun
    );

    modport slave (
        input  left, right, sample,
        output sclk, lrck, sdata, underrun, overrun
    );
endinterface

// File: rtl/jt03_i2s_tx.sv
// jt03_i2s_tx: serial audio transmitter with a one-deep sample holding buffer.
// Standard I2S by default; define JT03_I2S_LJ_EN for left-justified framing.
module jt03_i2s_tx #(
    parameter int DIV = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_en,
    jt03_i2s_tx_if.slave  bus
);

`ifdef JT03_I2S_LJ_EN
    localparam logic [4:0] LOAD_SLOT = 5'd0;
`else
    localparam logic [4:0] LOAD_SLOT = 5'd1;
`endif
    localparam int              CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   DIV_LAST = CW'(DIV - 1);

    logic [CW-1:0] div_q, div_d;
    logic          sclk_q, sclk_d;
    logic [4:0]    slot_q, slot_d;
    logic [31:0]   frame_q, frame_d;
    logic [31:0]   hold_q, hold_d;
    logic          hold_valid_q, hold_valid_d;
    logic          lrck_q, lrck_d;
    logic          sdata_q, sdata_d;
    logic          underrun_q, underrun_d;
    logic          overrun_q, overrun_d;

    logic          div_wrap;
    logic          fall;
    logic          load;
    logic          capture;
    logic [4:0]    slot_nxt;
    logic [4:0]    bit_idx;

    always_comb begin
        div_d        = div_q;
        sclk_d       = sclk_q;
        slot_d       = slot_q;
        frame_d      = frame_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        lrck_d       = lrck_q;
        sdata_d      = sdata_q;
        underrun_d   = 1'b0;
        overrun_d    = 1'b0;
        bit_idx      = 5'd0;

        div_wrap = (div_q == DIV_LAST);
        fall     = clk_en && div_wrap && sclk_q;
        slot_nxt = slot_q + 5'd1;
        load     = fall && (slot_nxt == LOAD_SLOT);
        capture  = clk_en && bus.sample;

        if (clk_en) begin
            div_d = div_wrap ? '0 : div_q + CW'(1);
            if (div_wrap) begin
                sclk_d = ~sclk_q;
            end
        end

        // A capture coinciding with the load bypasses the holding buffer.
        if (load) begin
            if (capture) begin
                frame_d      = {bus.left, bus.right};
                hold_valid_d = 1'b0;
                overrun_d    = hold_valid_q;
            end else if (hold_valid_q) begin
                frame_d      = hold_q;
                hold_valid_d = 1'b0;
            end else begin
                underrun_d   = 1'b1;
            end
        end else if (capture) begin
            hold_d       = {bus.left, bus.right};
            hold_valid_d = 1'b1;
            overrun_d    = hold_valid_q;
        end

        if (fall) begin
            slot_d = slot_nxt;
`ifdef JT03_I2S_LJ_EN
            bit_idx = 5'd31 - slot_nxt;
            lrck_d  = ~slot_nxt[4];
`else
            // Slot 0 wraps to index 0: the previous frame's right[0].
            bit_idx = 5'd0 - slot_nxt;
            lrck_d  = slot_nxt[4];
`endif
            sdata_d = frame_d[bit_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q        <= '0;
            sclk_q       <= 1'b0;
            slot_q       <= 5'd0;
            frame_q      <= 32'd0;
            hold_q       <= 32'd0;
            hold_valid_q <= 1'b0;
            lrck_q       <= 1'b0;
            sdata_q      <= 1'b0;
            underrun_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            div_q        <= div_d;
            sclk_q       <= sclk_d;
            slot_q       <= slot_d;
            frame_q      <= frame_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            lrck_q       <= lrck_d;
            sdata_q      <= sdata_d;
            underrun_q   <= underrun_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.sclk     = sclk_q;
    assign bus.lrck     = lrck_q;
    assign bus.sdata    = sdata_q;
    assign bus.underrun = underrun_q;
    assign bus.overrun  = overrun_q;

endmodule
